// File: rtl/instr_fetch.sv
// instr_fetch: fetch/issue sequencer that owns the PC and the instruction register (IR).
// Latency: at least 2 cycles per instruction (FETCH, ISSUE); each extra cycle without imem_ready adds one.
// Backpressure: stall holds ISSUE with pc/IR frozen; a missing imem_ready holds FETCH.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   imem_req/addr       read request to instruction memory; addr always equals pc
//   imem_ready/data     response; accepted only in FETCH
//   opcode..target      decoded fields of the IR, combinational
//   instr_valid, pc     the IR is being issued; pc is its address
//   jump, jump_sel,     control decisions for the issued instruction, sampled in ISSUE
//   branch, zero, reg_a
//   stall               downstream not ready; holds the issue
//   halted              fetch stopped (only with FETCH_SYSCALL_HALT_EN)
//
// Build option: define FETCH_SYSCALL_HALT_EN to make SYSCALL stop fetching.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] target,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        jump,
    input  logic        jump_sel,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] reg_a,
    input  logic        stall,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic        ir_load;
    logic        pc_load;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // JR targets are word aligned; the low address bits of reg_a carry no meaning here.
    logic unused_reg_a_lsbs;
    assign unused_reg_a_lsbs = &{1'b0, reg_a[1:0]};

    // Field decode straight off the IR so control sees stable values for the whole issue.
    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign target = ir[25:0];

    assign imem_addr = pc;

    // Both additions are 32 bits wide so the carry drops and the address wraps.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            if (jump_sel) begin
                next_pc = {reg_a[31:2], 2'b00};
            end else begin
                next_pc = {pc_plus4[31:28], target, 2'b00};
            end
        end else if (branch && !zero) begin
            next_pc = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        end
    end

`ifdef FETCH_SYSCALL_HALT_EN
    logic is_syscall;
    assign is_syscall = (ir[31:26] == 6'b000000) && (ir[5:0] == 6'b001100);
    assign halted     = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        case (state)
            FETCH: begin
                // The request is masked while reset is held so nothing goes out
                // before the first cycle after reset releases.
                imem_req = !reset;
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
`ifdef FETCH_SYSCALL_HALT_EN
                    if (is_syscall) begin
                        state_nxt = HALT;
                    end else begin
                        pc_load   = 1'b1;
                        state_nxt = FETCH;
                    end
`else
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
`endif
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= {RESET_PC[31:2], 2'b00};
            ir    <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir <= imem_data;
            end
            if (pc_load) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        instr_valid;
    logic [31:0] pc;
    logic        jump, jump_sel, branch, zero;
    logic [31:0] reg_a;
    logic        stall;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Scoreboard of fetch addresses the DUT must request next, in order.
    logic [31:0] exp_q[$];

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target), .instr_valid(instr_valid), .pc(pc),
        .jump(jump), .jump_sel(jump_sel), .branch(branch), .zero(zero),
        .reg_a(reg_a), .stall(stall), .halted(halted)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for a request, capture its address, answer after 'delay' cycles.
    // Called and returns on a negedge; on return the DUT is in ISSUE.
    task automatic fetch(input logic [31:0] data, input int delay,
                         output logic [31:0] addr, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            ok   = 1'b0;
            addr = 'x;
            return;
        end
        addr = imem_addr;
        repeat (delay) @(negedge clk);
        imem_ready = 1'b1;
        imem_data  = data;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    // Present control decisions for one ISSUE cycle with stall low.
    task automatic issue(input logic j, input logic js, input logic b, input logic z,
                         input logic [31:0] ra);
        jump = j; jump_sel = js; branch = b; zero = z; reg_a = ra; stall = 1'b0;
        @(negedge clk);
        jump = 1'b0; jump_sel = 1'b0; branch = 1'b0; zero = 1'b0; reg_a = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", pc); end
        checks++; if ({opcode, imm} !== 22'h0) begin errors++; $display("FAIL rst_ir: got %h/%h expected 0/0", opcode, imm); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
        exp_q.push_back(32'h0000_0000);
    endtask

    task automatic test_lw;
        logic [31:0] got, exp;
        bit ok;
        fetch(32'h8C08_0004, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL lw_addr: got %h expected %h", got, exp); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b expected 1", instr_valid); end
        checks++; if (opcode !== 6'h23) begin errors++; $display("FAIL lw_opcode: got %h expected 23", opcode); end
        checks++; if (rt !== 5'd8 || rs !== 5'd0) begin errors++; $display("FAIL lw_regs: got rs=%0d rt=%0d expected 0/8", rs, rt); end
        checks++; if (imm !== 16'h0004) begin errors++; $display("FAIL lw_imm: got %h expected 0004", imm); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL issue_req: got %b expected 0", imem_req); end
        issue(0, 0, 0, 0, 32'h0);
        exp_q.push_back(32'h0000_0004);
    endtask

    task automatic test_branch;
        logic [31:0] got, exp;
        bit ok;
        // JR to 0x10 to set up the BNE
        fetch(32'h0000_0008, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL br_setup_addr: got %h expected %h", got, exp); end
        issue(1, 1, 0, 0, 32'h0000_0010);
        exp_q.push_back(32'h0000_0010);
        // BNE taken: 0x14 - 8
        fetch(32'h1501_FFFE, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL bne_addr: got %h expected %h", got, exp); end
        checks++; if (opcode !== 6'h05 || imm !== 16'hFFFE) begin errors++; $display("FAIL bne_fields: got %h/%h expected 05/fffe", opcode, imm); end
        issue(0, 0, 1, 0, 32'h0);
        exp_q.push_back(32'h0000_000C);
        fetch(32'h0000_0008, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL bne_taken: got %h expected %h", got, exp); end
        issue(1, 1, 0, 0, 32'h0000_0010);
        exp_q.push_back(32'h0000_0010);
        // BNE not taken (zero=1)
        fetch(32'h1501_FFFE, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL bne2_addr: got %h expected %h", got, exp); end
        issue(0, 0, 1, 1, 32'h0);
        exp_q.push_back(32'h0000_0014);
    endtask

    task automatic test_jump;
        logic [31:0] got, exp;
        bit ok;
        fetch(32'h0000_0008, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL bne_not_taken: got %h expected %h", got, exp); end
        issue(1, 1, 0, 0, 32'h4000_0000);
        exp_q.push_back(32'h4000_0000);
        fetch(32'h0800_0040, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL j_addr: got %h expected %h", got, exp); end
        checks++; if (target !== 26'h000_0040 || pc !== 32'h4000_0000) begin errors++; $display("FAIL j_fields: got %h/%h expected 0000040/40000000", target, pc); end
        issue(1, 0, 0, 0, 32'h0);
        exp_q.push_back(32'h4000_0100);
        fetch(32'h0000_0008, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL j_target: got %h expected %h", got, exp); end
        issue(1, 1, 0, 0, 32'h0000_0123);
        exp_q.push_back(32'h0000_0120);
        // jump and branch together: jump wins (branch would give 0x128)
        fetch(32'h1000_0001, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL jr_target: got %h expected %h", got, exp); end
        issue(1, 1, 1, 0, 32'h0000_0200);
        exp_q.push_back(32'h0000_0200);
    endtask

    task automatic test_stall;
        logic [31:0] exp, pc0;
        int req_n, val_n;
        logic pc_bad;
        exp = exp_q.pop_front();
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp) begin errors++; $display("FAIL stall_addr: got %h expected %h", imem_addr, exp); end
        pc0 = exp; req_n = 0; val_n = 0; pc_bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            imem_ready = (i >= 3);
            imem_data  = (i == 3) ? 32'h0109_5020 : 32'hFFFF_FFFF;
            stall      = (i == 4 || i == 5);
            if (imem_req === 1'b1) req_n++;
            if (instr_valid === 1'b1) val_n++;
            if (pc !== pc0) pc_bad = 1'b1;
            if (i == 6) begin
                checks++; if (funct !== 6'h20 || rd !== 5'd10 || rt !== 5'd9) begin errors++; $display("FAIL stall_ir: got funct=%h rd=%0d rt=%0d expected 20/10/9", funct, rd, rt); end
            end
            @(negedge clk);
        end
        imem_ready = 1'b0; stall = 1'b0;
        checks++; if (req_n != 4) begin errors++; $display("FAIL stall_req_cycles: got %0d expected 4", req_n); end
        checks++; if (val_n != 3) begin errors++; $display("FAIL stall_valid_cycles: got %0d expected 3", val_n); end
        checks++; if (pc_bad) begin errors++; $display("FAIL stall_pc: got change expected constant %h", pc0); end
        exp_q.push_back(32'h0000_0204);
    endtask

    task automatic test_wrap;
        logic [31:0] got, exp;
        bit ok;
        fetch(32'h0000_0008, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL stall_next: got %h expected %h", got, exp); end
        issue(1, 1, 0, 0, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        fetch(32'h0109_5020, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL wrap_addr: got %h expected %h", got, exp); end
        issue(0, 0, 0, 0, 32'h0);
        exp_q.push_back(32'h0000_0000);
    endtask

    task automatic test_syscall;
        logic [31:0] got, exp;
        bit ok;
        fetch(32'h0000_000C, 0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL wrap_next: got %h expected %h", got, exp); end
        issue(0, 0, 0, 0, 32'h0);
`ifdef FETCH_SYSCALL_HALT_EN
        begin
            int req_n = 0;
            int val_n = 0;
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sys_halted: got %b expected 1", halted); end
            for (int i = 0; i < 10; i++) begin
                imem_ready = 1'b1;
                if (imem_req !== 1'b0) req_n++;
                if (instr_valid !== 1'b0) val_n++;
                @(negedge clk);
            end
            imem_ready = 1'b0;
            checks++; if (req_n != 0 || val_n != 0) begin errors++; $display("FAIL sys_quiet: got req=%0d valid=%0d expected 0/0", req_n, val_n); end
            checks++; if (pc !== 32'h0) begin errors++; $display("FAIL sys_pc: got %h expected 00000000", pc); end
        end
`else
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sys_halted: got %b expected 0", halted); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL sys_next: got %b/%h expected 1/00000004", imem_req, imem_addr); end
`endif
    endtask

    task automatic test_reset_mid_fetch;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_pre: got %b/%h expected 1/00000000", imem_req, imem_addr); end
        reset = 1'b1; imem_ready = 1'b1; imem_data = 32'h8C08_0004; stall = 1'b1; jump = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b expected 0", imem_req); end
        @(negedge clk);
        checks++; if (opcode !== 6'h0 || imm !== 16'h0) begin errors++; $display("FAIL mid_ir: got %h/%h expected 0/0", opcode, imm); end
        checks++; if (pc !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_state: got pc=%h valid=%b expected 0/0", pc, instr_valid); end
        reset = 1'b0; imem_ready = 1'b0; stall = 1'b0; jump = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || opcode !== 6'h0 || halted !== 1'b0) begin errors++; $display("FAIL mid_after: got req=%b op=%h halted=%b expected 1/0/0", imem_req, opcode, halted); end
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_data = '0;
        jump = 1'b0; jump_sel = 1'b0; branch = 1'b0; zero = 1'b0; reg_a = '0; stall = 1'b0;
        @(negedge clk);
        test_reset;
        test_lw;
        test_branch;
        test_jump;
        test_stall;
        test_wrap;
        test_syscall;
        test_reset_mid_fetch;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
